ysyx_23060201_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060201_mem_arbiter

Overview:
- Arbitrates one shared memory port between instruction fetch (m0, IFU) and load/store (m1, LSU).
- Replaces the direct PC-to-MEM hookup once the core moves to a multi-cycle fetch/execute flow.
- Allows one outstanding transaction; the grant is held from request acceptance until the master accepts the response.
- Fixed priority LSU > IFU, with a starvation guard and a response-timeout watchdog.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive m1 grants while m0 is pending before m0 is forced priority (1..15)
- TIMEOUT, 255, cycles waiting on the slave response before abort (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- m0_req_valid / m0_req_ready  in/out  1  IFU request handshake
- m0_addr  in  AW  IFU address; read-only master
- m0_resp_valid / m0_resp_ready  out/in  1  IFU response handshake
- m0_rdata  out  DW  IFU read data
- m0_err  out  1  IFU response error (timeout)
- m1_req_valid / m1_req_ready  in/out  1  LSU request handshake
- m1_addr  in  AW  LSU address
- m1_wen  in  1  LSU write enable
- m1_wdata  in  DW  LSU write data
- m1_wmask  in  DW/8  LSU byte mask
- m1_resp_valid / m1_resp_ready  out/in  1  LSU response handshake
- m1_rdata  out  DW  LSU read data
- m1_err  out  1  LSU response error (timeout)
- s_req_valid / s_req_ready  out/in  1  slave request handshake
- s_addr, s_wen, s_wdata, s_wmask  out  AW/1/DW/DW/8  slave request payload
- s_resp_valid  in  1  slave response strobe; no backpressure toward slave
- s_rdata  in  DW  slave read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=m0, starve_cnt=0, tmo_cnt=0.
  - All valid/ready outputs, *_err, busy and data outputs are 0.
- Handshake rule: a transfer occurs when valid && ready are both high on a rising edge.
- Slave request payload stability:
  - Masters hold payload stable while valid and not ready.
  - The arbiter registers the payload at acceptance and drives s_* from those registers.
- FSM states: IDLE, SREQ, SRESP, MRESP.
- IDLE:
  - Arbitrate among the pending valids.
  - m1 wins unless starve_cnt==STARVE_MAX, in which case m0 wins.
  - On a win, assert mX_req_ready for exactly one cycle (combinational in IDLE only).
  - Latch the payload; m0 requests latch wen=0 and wmask=0.
  - Go to SREQ next cycle.
  - No requests: stay in IDLE.
  - Minimum latency: request accept in cycle 0, s_req_valid in cycle 1.
- starve_cnt:
  - Increments when m1 wins while m0_req_valid=1, saturating at STARVE_MAX.
  - Clears when m0 wins or when m0_req_valid=0 in IDLE.
- SREQ:
  - s_req_valid=1 with the latched payload.
  - On s_req_ready: go to SRESP with tmo_cnt=0.
  - tmo_cnt also runs in SREQ; timeout here aborts the same way as in SRESP.
- SRESP:
  - tmo_cnt increments each cycle.
  - On s_resp_valid: latch s_rdata, err=0, go to MRESP.
  - When tmo_cnt reaches TIMEOUT: latch rdata=0, err=1, go to MRESP.
  - s_resp_valid and timeout in the same cycle: the response wins, err=0.
- MRESP:
  - Granted mX_resp_valid=1 with rdata/err held until mX_resp_ready.
  - Then go to IDLE; a new arbitration may occur in the next cycle.
  - The non-granted master's resp_valid stays 0.
- Late slave response: s_resp_valid arriving outside SRESP (after an abort) is ignored.
- Widths: tmo_cnt is 8 bits; starve_cnt is 4 bits; no wrap (both saturate or clear as specified).
- Mid-transaction reset: returns to IDLE immediately and drops all valids; the in-flight transaction is lost and neither master gets a response.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, SREQ=2'd1, SRESP=2'd2, MRESP=2'd3);
  - master index constants M_IFU=0, M_LSU=1;
  - defaults for AW, DW, STARVE_MAX, TIMEOUT.
- One natural sub-module: ysyx_23060201_arb_pick.
  - Combinational priority-plus-starvation selector.
  - Inputs: m0/m1 valids, starve_cnt.
  - Outputs: grant index and grant-valid.
- FSM, payload registers and watchdog stay in the top.

Test Plan:
- m0 only, addr=0x80000000, slave ready immediately, response after 2 cycles with 0x00000413 -> m0_req_ready in cycle 0, s_req_valid in cycle 1, m0_resp_valid with rdata=0x00000413, err=0.
- m0 and m1 both valid in the same cycle, m1 write addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF -> m1 granted first with s_wen=1 and the correct payload; m0 served in the next transaction.
- m0 held valid, m1 issues back-to-back requests (STARVE_MAX=4) -> m1 wins 4 transactions, m0 wins the 5th, starve_cnt returns to 0.
- Slave never asserts s_resp_valid, TIMEOUT=255 -> m*_resp_valid with err=1 and rdata=0 after 255 SRESP cycles; a late s_resp_valid is ignored and the FSM returns to IDLE.
- m1_resp_ready held low for 5 cycles in MRESP -> rdata/err stay stable, no new grant, busy=1 throughout.
- rst driven low asynchronously while in SRESP -> all outputs 0 and state IDLE before the next clk edge; a fresh m0 request after rst=1 completes normally.

Source files
------------

// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared constants for the IFU/LSU memory-port arbiter.
package ysyx_23060201_mem_arbiter_pkg;

    localparam int unsigned AW_DEF         = 32;
    localparam int unsigned DW_DEF         = 32;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 255;

    localparam int unsigned TMO_W    = 8;
    localparam int unsigned STARVE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SREQ  = 2'd1,
        SRESP = 2'd2,
        MRESP = 2'd3
    } state_t;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060201_arb_pick.sv
// Fixed-priority (LSU over IFU) selector; a saturated starvation count hands the win to the IFU.
module ysyx_23060201_arb_pick
    import ysyx_23060201_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                m0_valid,
    input  logic                m1_valid,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                grant_c,
    output logic                grant_valid_c
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic force_m0;

    always_comb begin
        force_m0      = m0_valid && (starve_cnt == STARVE_LIM);
        grant_valid_c = m0_valid || m1_valid;
        grant_c       = (m1_valid && !force_m0) ? M_LSU : M_IFU;
    end

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Shares one memory port between IFU (m0) and LSU (m1) with a single outstanding
// transaction, a starvation guard for the IFU and a slave-response watchdog.
module ysyx_23060201_mem_arbiter
    import ysyx_23060201_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic [AW-1:0]   m0_addr,
    output logic            m0_resp_valid,
    input  logic            m0_resp_ready,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_err,

    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_wen,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    output logic            m1_resp_valid,
    input  logic            m1_resp_ready,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_err,

    output logic            s_req_valid,
    input  logic            s_req_ready,
    output logic [AW-1:0]   s_addr,
    output logic            s_wen,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wmask,
    input  logic            s_resp_valid,
    input  logic [DW-1:0]   s_rdata,

    output logic            busy
);

    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    state_t              state_q,  state_d;
    logic                grant_q,  grant_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [TMO_W-1:0]    tmo_q,    tmo_d;
    logic [AW-1:0]       addr_q,   addr_d;
    logic                wen_q,    wen_d;
    logic [DW-1:0]       wdata_q,  wdata_d;
    logic [DW/8-1:0]     wmask_q,  wmask_d;
    logic [DW-1:0]       rdata_q,  rdata_d;
    logic                err_q,    err_d;

    logic pick_grant_c;
    logic pick_valid_c;
    logic resp_ack;

    ysyx_23060201_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .m0_valid      (m0_req_valid),
        .m1_valid      (m1_req_valid),
        .starve_cnt    (starve_q),
        .grant_c       (pick_grant_c),
        .grant_valid_c (pick_valid_c)
    );

    // State and transaction registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            grant_q  <= M_IFU;
            starve_q <= '0;
            tmo_q    <= '0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign resp_ack = (grant_q == M_IFU) ? m0_resp_ready : m1_resp_ready;

    // Next-state, payload capture, starvation and watchdog logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        starve_d     = starve_q;
        tmo_d        = tmo_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (!m0_req_valid) begin
                    starve_d = '0;
                end
                if (pick_valid_c) begin
                    grant_d = pick_grant_c;
                    state_d = SREQ;
                    if (pick_grant_c == M_LSU) begin
                        m1_req_ready = rst;
                        addr_d       = m1_addr;
                        wen_d        = m1_wen;
                        wdata_d      = m1_wdata;
                        wmask_d      = m1_wmask;
                        if (m0_req_valid && (starve_q != STARVE_LIM)) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end else begin
                        m0_req_ready = rst;
                        addr_d       = m0_addr;
                        wen_d        = 1'b0;
                        wdata_d      = '0;
                        wmask_d      = '0;
                        starve_d     = '0;
                    end
                end
            end
            SREQ: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (s_req_ready) begin
                    state_d = SRESP;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = MRESP;
                end
            end
            SRESP: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (s_resp_valid) begin
                    rdata_d = s_rdata;
                    err_d   = 1'b0;
                    state_d = MRESP;
                end else if (tmo_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = MRESP;
                end
            end
            MRESP: begin
                if (resp_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response data is only exposed to the master that owns the transaction
    assign s_req_valid   = (state_q == SREQ);
    assign s_addr        = addr_q;
    assign s_wen         = wen_q;
    assign s_wdata       = wdata_q;
    assign s_wmask       = wmask_q;
    assign busy          = (state_q != IDLE);
    assign m0_resp_valid = (state_q == MRESP) && (grant_q == M_IFU);
    assign m1_resp_valid = (state_q == MRESP) && (grant_q == M_LSU);
    assign m0_rdata      = m0_resp_valid ? rdata_q : '0;
    assign m1_rdata      = m1_resp_valid ? rdata_q : '0;
    assign m0_err        = m0_resp_valid && err_q;
    assign m1_err        = m1_resp_valid && err_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed scoreboard bench for the IFU/LSU memory arbiter.
module tb_ysyx_23060201_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready, m0_err;
    logic [31:0] m0_addr, m0_rdata;
    logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic        s_req_valid, s_req_ready, s_wen, s_resp_valid, busy;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;

    typedef struct {
        logic        m;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   starve_m    = 0;

    ysyx_23060201_mem_arbiter #(
        .AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(255)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_req_valid  (m0_req_valid),
        .m0_req_ready  (m0_req_ready),
        .m0_addr       (m0_addr),
        .m0_resp_valid (m0_resp_valid),
        .m0_resp_ready (m0_resp_ready),
        .m0_rdata      (m0_rdata),
        .m0_err        (m0_err),
        .m1_req_valid  (m1_req_valid),
        .m1_req_ready  (m1_req_ready),
        .m1_addr       (m1_addr),
        .m1_wen        (m1_wen),
        .m1_wdata      (m1_wdata),
        .m1_wmask      (m1_wmask),
        .m1_resp_valid (m1_resp_valid),
        .m1_resp_ready (m1_resp_ready),
        .m1_rdata      (m1_rdata),
        .m1_err        (m1_err),
        .s_req_valid   (s_req_valid),
        .s_req_ready   (s_req_ready),
        .s_addr        (s_addr),
        .s_wen         (s_wen),
        .s_wdata       (s_wdata),
        .s_wmask       (s_wmask),
        .s_resp_valid  (s_resp_valid),
        .s_rdata       (s_rdata),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Current cycle is IDLE with requests driven: check the grant and push the expected transaction
    task automatic accept(input logic m, input logic [31:0] rd, input logic er);
        exp_t e;
        settle();
        chk("m0_req_ready", 64'(m0_req_ready), 64'(m == 1'b0));
        chk("m1_req_ready", 64'(m1_req_ready), 64'(m == 1'b1));
        e.m = m;
        if (m) begin
            e.addr = m1_addr; e.wen = m1_wen; e.wdata = m1_wdata; e.wmask = m1_wmask;
        end else begin
            e.addr = m0_addr; e.wen = 1'b0; e.wdata = 32'h0; e.wmask = 4'h0;
        end
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
        step();
    endtask

    task automatic sreq_chk();
        exp_t e;
        settle();
        chk("sb_depth", 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb[0];
            chk("s_req_valid", 64'(s_req_valid), 64'd1);
            chk("s_addr",  64'(s_addr),  64'(e.addr));
            chk("s_wen",   64'(s_wen),   64'(e.wen));
            chk("s_wdata", 64'(s_wdata), 64'(e.wdata));
            chk("s_wmask", 64'(s_wmask), 64'(e.wmask));
            chk("req_ready_sreq", 64'({m0_req_ready, m1_req_ready}), 64'd0);
        end
    endtask

    task automatic respond(input int lat, input logic [31:0] d);
        step();
        repeat (lat) step();
        s_resp_valid = 1'b1;
        s_rdata      = d;
        step();
        s_resp_valid = 1'b0;
        s_rdata      = 32'h0;
    endtask

    task automatic mresp_chk();
        exp_t e;
        settle();
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("m0_resp_valid", 64'(m0_resp_valid), 64'(e.m == 1'b0));
            chk("m1_resp_valid", 64'(m1_resp_valid), 64'(e.m == 1'b1));
            chk("resp_rdata", 64'(e.m ? m1_rdata : m0_rdata), 64'(e.rdata));
            chk("resp_err",   64'(e.m ? m1_err : m0_err),     64'(e.err));
            chk("busy_mresp", 64'(busy), 64'd1);
        end
        step();
    endtask

    initial begin
        int  n;
        logic win;
        rst = 1'b0;
        m0_req_valid = 1'b1; m0_addr = 32'h0; m0_resp_ready = 1'b0;
        m1_req_valid = 1'b1; m1_addr = 32'h0; m1_wen = 1'b0; m1_wdata = 32'h0; m1_wmask = 4'h0;
        m1_resp_ready = 1'b0; s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = 32'h0;
        repeat (2) step();
        settle();
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_ready",     64'({m0_req_ready, m1_req_ready}), 64'd0);
        chk("rst_valids",    64'({s_req_valid, m0_resp_valid, m1_resp_valid}), 64'd0);
        chk("rst_errs",      64'({m0_err, m1_err}), 64'd0);
        chk("rst_payload",   64'({s_addr, s_wen, s_wmask}), 64'd0);
        chk("rst_data",      64'({m0_rdata, m1_rdata}), 64'd0);

        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        m0_resp_ready = 1'b1; m1_resp_ready = 1'b1; s_req_ready = 1'b1;
        rst = 1'b1;
        step();

        // m0 alone: accept in cycle 0, s_req_valid in cycle 1
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0000;
        accept(1'b0, 32'h0000_0413, 1'b0);
        m0_req_valid = 1'b0;
        sreq_chk();
        respond(1, 32'h0000_0413);
        mresp_chk();
        settle();
        chk("idle_after_t1", 64'(busy), 64'd0);

        // Simultaneous requests: LSU write first, then IFU; payload must be the latched copy
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0004;
        m1_req_valid = 1'b1; m1_addr = 32'h8000_1000; m1_wen = 1'b1;
        m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF;
        accept(1'b1, 32'h0, 1'b0);
        m1_req_valid = 1'b0; m1_wen = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wmask = 4'h0;
        sreq_chk();
        respond(0, 32'h0);
        mresp_chk();
        accept(1'b0, 32'h0000_0011, 1'b0);
        m0_req_valid = 1'b0;
        sreq_chk();
        respond(0, 32'h0000_0011);
        mresp_chk();

        // Starvation: m0 pending while m1 keeps requesting
        starve_m = 0;
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0100;
        m1_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            m1_addr = 32'h8000_2000 + 32'(i * 4);
            win = (starve_m == 4) ? 1'b0 : 1'b1;
            starve_m = win ? starve_m + 1 : 0;
            accept(win, 32'h1000 + 32'(i), 1'b0);
            if (i == 4) begin
                m0_req_valid = 1'b0;
                m1_req_valid = 1'b0;
            end
            sreq_chk();
            respond(0, 32'h1000 + 32'(i));
            mresp_chk();
        end
        m0_req_valid = 1'b1; m1_req_valid = 1'b1; m1_addr = 32'h8000_2100;
        accept(1'b1, 32'h0000_0077, 1'b0);
        m0_req_valid = 1'b0; m1_req_valid = 1'b0;
        sreq_chk();
        respond(0, 32'h0000_0077);
        mresp_chk();

        // Watchdog: no slave response, abort after 255 SRESP cycles, late responses ignored
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0200;
        accept(1'b0, 32'h0, 1'b1);
        m0_req_valid = 1'b0;
        sreq_chk();
        step();
        n = 0;
        while (!m0_resp_valid && n < 400) begin
            step();
            n++;
        end
        chk("tmo_cycles", 64'(n), 64'd255);
        m0_resp_ready = 1'b0;
        s_resp_valid  = 1'b1;
        s_rdata       = 32'hBAD0_BAD0;
        step();
        settle();
        chk("late_resp_valid", 64'(m0_resp_valid), 64'd1);
        chk("late_resp_rdata", 64'(m0_rdata), 64'd0);
        chk("late_resp_err",   64'(m0_err), 64'd1);
        s_resp_valid = 1'b0; s_rdata = 32'h0;
        m0_resp_ready = 1'b1;
        mresp_chk();
        s_resp_valid = 1'b1; s_rdata = 32'hBAD1_BAD1;
        step();
        settle();
        chk("stray_resp_idle", 64'(busy), 64'd0);
        s_resp_valid = 1'b0; s_rdata = 32'h0;

        // Response backpressure: held data, no new grant while m0 waits
        m1_req_valid = 1'b1; m1_addr = 32'h8000_3000; m1_wen = 1'b0; m1_resp_ready = 1'b0;
        accept(1'b1, 32'hCAFE_F00D, 1'b0);
        m1_req_valid = 1'b0;
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0300;
        sreq_chk();
        respond(0, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("hold_valid", 64'(m1_resp_valid), 64'd1);
            chk("hold_rdata", 64'(m1_rdata), 64'hCAFE_F00D);
            chk("hold_err",   64'(m1_err), 64'd0);
            chk("hold_busy",  64'(busy), 64'd1);
            chk("hold_nogrant", 64'({m0_req_ready, m1_req_ready}), 64'd0);
            step();
        end
        m1_resp_ready = 1'b1;
        mresp_chk();
        accept(1'b0, 32'h0000_0055, 1'b0);
        m0_req_valid = 1'b0;
        sreq_chk();
        respond(0, 32'h0000_0055);
        mresp_chk();

        // Asynchronous reset during SRESP drops the transaction
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0400;
        accept(1'b0, 32'h0, 1'b0);
        m0_req_valid = 1'b0;
        sreq_chk();
        step();
        step();
        settle();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        settle();
        chk("arst_busy",    64'(busy), 64'd0);
        chk("arst_valids",  64'({s_req_valid, m0_resp_valid, m1_resp_valid}), 64'd0);
        chk("arst_payload", 64'(s_addr), 64'd0);
        chk("arst_data",    64'({m0_err, m1_err, m0_rdata}), 64'd0);
        sb.delete();
        step();
        rst = 1'b1;
        step();
        m0_req_valid = 1'b1; m0_addr = 32'h8000_0500;
        accept(1'b0, 32'h1234_5678, 1'b0);
        m0_req_valid = 1'b0;
        sreq_chk();
        respond(1, 32'h1234_5678);
        mresp_chk();

        chk("sb_final", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
